// File: rtl/prog_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : prog_mod_counter
//  Purpose  : Runtime-programmable modulo-M up/down counter. Modulus is
//             reprogrammable at run time; a written modulus stays pending
//             until the next wrap step or load, so a counting sequence is
//             never cut short in the middle of a period.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH    counter / modulus width (2..32)
//    N_INIT   modulus after reset, 0 encodes 2^WIDTH
//    PRESC_W  prescaler width (used only with PROG_MOD_COUNTER_PRESCALE_EN)
//  Ports
//    clk       in   clock, rising edge
//    rstn      in   synchronous active-low reset
//    en        in   count enable
//    up_dn     in   1 = up, 0 = down
//    load      in   parallel load strobe (clamped to M-1)
//    load_val  in   load value
//    mod_wr    in   modulus write strobe
//    mod_n     in   new modulus, 0 = 2^WIDTH
//    presc     in   prescale divisor minus 1 (macro builds only)
//    count     out  registered count
//    tc        out  registered terminal-count pulse, aligned with wrapped count
//    casc      out  combinational: this cycle's step wraps
//    mod_pend  out  a written modulus awaits application
//  Build option
//    PROG_MOD_COUNTER_PRESCALE_EN  adds the enabled-cycle prescaler
// ============================================================================
module prog_mod_counter #(
   parameter int WIDTH   = 8,
   parameter int N_INIT  = 15,
   parameter int PRESC_W = 4
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               en,
   input  logic               up_dn,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_val,
   input  logic               mod_wr,
   input  logic [WIDTH-1:0]   mod_n,
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
   input  logic [PRESC_W-1:0] presc,
`endif
   output logic [WIDTH-1:0]   count,
   output logic               tc,
   output logic               casc,
   output logic               mod_pend
);

   localparam logic [WIDTH-1:0] N_INIT_V = WIDTH'(N_INIT);
   localparam logic [WIDTH:0]   ONE_X    = (WIDTH+1)'(1);

   if (WIDTH < 2 || WIDTH > 32 || PRESC_W < 1) begin : g_param_check
      $error("prog_mod_counter: parameter out of range");
   end

   logic [WIDTH-1:0] m_active;
   logic [WIDTH-1:0] m_pending;
   logic             tick;
   logic             step;
   logic             wrap;
   logic             at_term;
   logic             apply;
   logic [WIDTH:0]   m_cur;      // modulus governing this cycle's wrap test
   logic [WIDTH:0]   m_new;      // modulus in force after this edge
   logic [WIDTH:0]   m_new_m1;
   logic [WIDTH:0]   load_x;
   logic [WIDTH:0]   load_clamp;
   logic [WIDTH-1:0] count_nxt;

   // Moduli are widened by one bit so that 0 can stand for 2^WIDTH.
   function automatic logic [WIDTH:0] eff_mod(input logic [WIDTH-1:0] m);
      return (m == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, m};
   endfunction

`ifdef PROG_MOD_COUNTER_PRESCALE_EN
   logic [PRESC_W-1:0] presc_cnt;

   assign tick = (presc_cnt == presc);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         presc_cnt <= '0;
      end else if (load) begin
         presc_cnt <= '0;
      end else if (en) begin
         presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
      end
   end
`else
   assign tick = 1'b1;
`endif

   always_comb begin
      m_cur      = eff_mod(m_active);
      // A pending modulus takes effect in the same edge that applies it.
      m_new      = eff_mod(mod_pend ? m_pending : m_active);
      m_new_m1   = m_new - ONE_X;
      step       = en & tick;
      at_term    = up_dn ? ({1'b0, count} == (m_cur - ONE_X)) : (count == '0);
      wrap       = step & at_term;
      apply      = load | wrap;
      load_x     = {1'b0, load_val};
      load_clamp = (load_x >= m_new) ? m_new_m1 : load_x;

      count_nxt  = count;
      if (load) begin
         count_nxt = load_clamp[WIDTH-1:0];
      end else if (wrap) begin
         count_nxt = up_dn ? '0 : m_new_m1[WIDTH-1:0];
      end else if (step) begin
         count_nxt = up_dn ? count + WIDTH'(1) : count - WIDTH'(1);
      end
   end

   // Load wins over step, so a load cycle never reports a wrap.
   assign casc = wrap & ~load;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         count     <= '0;
         tc        <= 1'b0;
         m_active  <= N_INIT_V;
         m_pending <= N_INIT_V;
         mod_pend  <= 1'b0;
      end else begin
         count <= count_nxt;
         tc    <= wrap & ~load;
         if (apply && mod_pend) begin
            m_active <= m_pending;
            mod_pend <= 1'b0;
         end
         // A write coinciding with an apply becomes the next pending value.
         if (mod_wr) begin
            m_pending <= mod_n;
            mod_pend  <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_prog_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_mod_counter
//  Purpose  : Self-checking bench for prog_mod_counter (WIDTH=4, N_INIT=15).
//             Directed sequences with literal expectations, then randomized
//             traffic compared every cycle against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_mod_counter;

   localparam int W = 4;
   localparam int FULL = 1 << W;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         en = 1'b0;
   logic         up_dn = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         mod_wr = 1'b0;
   logic [W-1:0] mod_n = '0;
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
   logic [3:0]   presc = '0;
`endif
   logic [W-1:0] count;
   logic         tc;
   logic         casc;
   logic         mod_pend;

   int nchecks = 0;
   int nerrors = 0;
   bit chk_en = 1'b0;

   // model state
   int m_cnt, m_act, m_pv, m_pre;
   bit m_pend, m_tc;

   prog_mod_counter #(.WIDTH(W), .N_INIT(15), .PRESC_W(4)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .en       (en),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (load_val),
      .mod_wr   (mod_wr),
      .mod_n    (mod_n),
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
      .presc    (presc),
`endif
      .count    (count),
      .tc       (tc),
      .casc     (casc),
      .mod_pend (mod_pend)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      nchecks++;
      if (act != exp) begin
         nerrors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int eff(input int m);
      return (m == 0) ? FULL : m;
   endfunction

   function automatic bit model_tick();
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
      return (m_pre == int'(presc));
`else
      return 1'b1;
`endif
   endfunction

   // Behavioural model: the count lives in Z_M, steps are +1 / -1 mod M.
   always @(posedge clk) begin
      int mc, mn;
      bit stp, wrp;
      if (!rstn) begin
         m_cnt = 0; m_act = 15; m_pv = 15; m_pend = 0; m_tc = 0; m_pre = 0;
      end else begin
         mc  = eff(m_act);
         mn  = m_pend ? eff(m_pv) : mc;
         stp = en && model_tick();
         wrp = stp && (up_dn ? (m_cnt == mc - 1) : (m_cnt == 0));
         if (load) begin
            m_cnt = (int'(load_val) >= mn) ? mn - 1 : int'(load_val);
            m_tc  = 0;
            m_pre = 0;
         end else begin
            if (wrp)      m_cnt = up_dn ? 0 : mn - 1;
            else if (stp) m_cnt = (m_cnt + (up_dn ? 1 : mc - 1)) % mc;
            m_tc = wrp;
            if (en) m_pre = model_tick() ? 0 : (m_pre + 1) % 16;
         end
         if ((load || wrp) && m_pend) begin
            m_act  = m_pv;
            m_pend = 0;
         end
         if (mod_wr) begin
            m_pv   = int'(mod_n);
            m_pend = 1;
         end
      end
   end

   // Every-cycle compare, half a period away from the active edge.
   always @(negedge clk) begin
      int mc;
      bit at;
      if (chk_en) begin
         check("count",    int'(count),    m_cnt);
         check("tc",       int'(tc),       int'(m_tc));
         check("mod_pend", int'(mod_pend), int'(m_pend));
         if (rstn) begin
            mc = eff(m_act);
            at = up_dn ? (m_cnt == mc - 1) : (m_cnt == 0);
            check("casc", int'(casc), int'(en && model_tick() && !load && at));
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // reset
      cyc(2);
      chk_en = 1'b1;
      check("rst_count", int'(count), 0);
      check("rst_tc", int'(tc), 0);
      check("rst_mod_pend", int'(mod_pend), 0);
      rstn = 1'b1;

      // up count M=15
      en = 1'b1; up_dn = 1'b1;
      cyc(14);
      check("up_cnt14", int'(count), 14);
      check("up_casc14", int'(casc), 1);
      cyc(1);
      check("up_wrap", int'(count), 0);
      check("up_wrap_tc", int'(tc), 1);
      cyc(1);
      check("up_tc_off", int'(tc), 0);

      // modulus 15 -> 5 written mid-period
      cyc(2);
      mod_wr = 1'b1; mod_n = 4'd5;
      cyc(1);
      mod_wr = 1'b0;
      check("pend_set", int'(mod_pend), 1);
      cyc(10);
      check("pend_cnt14", int'(count), 14);
      cyc(1);
      check("pend_wrap", int'(count), 0);
      check("pend_clear", int'(mod_pend), 0);
      cyc(4);
      check("m5_cnt4", int'(count), 4);
      check("m5_casc", int'(casc), 1);
      cyc(1);
      check("m5_wrap", int'(count), 0);

      // down count M=10, clamped load
      en = 1'b0; mod_wr = 1'b1; mod_n = 4'd10;
      cyc(1);
      mod_wr = 1'b0; load = 1'b1; load_val = 4'd0;
      cyc(1);
      load = 1'b0; en = 1'b1; up_dn = 1'b0;
      cyc(1);
      check("dn_wrap", int'(count), 9);
      check("dn_wrap_tc", int'(tc), 1);
      load = 1'b1; load_val = 4'd12;
      cyc(1);
      check("load_clamp", int'(count), 9);
      check("load_no_tc", int'(tc), 0);
      load = 1'b0; en = 1'b0;

      // M=1
      mod_wr = 1'b1; mod_n = 4'd1;
      cyc(1);
      mod_wr = 1'b0; load = 1'b1; load_val = 4'd7;
      cyc(1);
      check("m1_clamp", int'(count), 0);
      load = 1'b0; en = 1'b1;
      cyc(2);
      check("m1_cnt", int'(count), 0);
      check("m1_tc", int'(tc), 1);

      // mod_n=0 (2^WIDTH) written during a wrap step
      up_dn = 1'b1; mod_wr = 1'b1; mod_n = 4'd0;
      cyc(1);
      mod_wr = 1'b0;
      check("m0_pend", int'(mod_pend), 1);
      cyc(1);
      check("m0_applied", int'(mod_pend), 0);
      cyc(15);
      check("m0_cnt15", int'(count), 15);
      cyc(1);
      check("m0_wrap", int'(count), 0);
      check("m0_tc", int'(tc), 1);

      // reset mid-count with pending modulus
      cyc(3);
      mod_wr = 1'b1; mod_n = 4'd6;
      cyc(1);
      mod_wr = 1'b0; rstn = 1'b0;
      cyc(1);
      check("rst2_count", int'(count), 0);
      check("rst2_pend", int'(mod_pend), 0);
      rstn = 1'b1;
      cyc(14);
      check("rst2_cnt14", int'(count), 14);
      cyc(1);
      check("rst2_wrap", int'(count), 0);

`ifdef PROG_MOD_COUNTER_PRESCALE_EN
      en = 1'b0; mod_wr = 1'b1; mod_n = 4'd4;
      cyc(1);
      mod_wr = 1'b0; load = 1'b1; load_val = 4'd0;
      cyc(1);
      load = 1'b0; presc = 4'd2; en = 1'b1;
      cyc(2);
      check("psc_hold", int'(count), 0);
      cyc(1);
      check("psc_step", int'(count), 1);
      en = 1'b0;
      cyc(5);
      check("psc_freeze", int'(count), 1);
      en = 1'b1;
      cyc(2);
      check("psc_resume", int'(count), 1);
      cyc(1);
      check("psc_step2", int'(count), 2);
`endif

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rstn     = ($urandom_range(0, 199) != 0);
         en       = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) up_dn = ~up_dn;
         load     = ($urandom_range(0, 19) == 0);
         load_val = W'($urandom_range(0, 15));
         mod_wr   = ($urandom_range(0, 11) == 0);
         mod_n    = W'($urandom_range(0, 15));
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
         if ($urandom_range(0, 63) == 0) presc = 4'($urandom_range(0, 3));
`endif
         cyc(1);
      end

      rstn = 1'b1; en = 1'b0; load = 1'b0; mod_wr = 1'b0;
      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
`default_nettype wire
